// File: rtl/drum_audio_tap_if.sv
// Handshake bundle between the column simulation, drum_audio_tap and the audio FIFO.
// The master modport is the tap block; the slave modport is the simulation/FIFO side.
interface drum_audio_tap_if;
  logic signed [17:0] u_sample;
  logic        [5:0]  row_idx;
  logic               sample_valid;
  logic               step_done;
  logic               step_en;
  logic        [31:0] audio_data;
  logic               audio_valid;
  logic               audio_ready;

  modport master (
    input  u_sample,
    input  row_idx,
    input  sample_valid,
    input  step_done,
    input  audio_ready,
    output step_en,
    output audio_data,
    output audio_valid
  );

  modport slave (
    output u_sample,
    output row_idx,
    output sample_valid,
    output step_done,
    output audio_ready,
    input  step_en,
    input  audio_data,
    input  audio_valid
  );
endinterface

// File: rtl/drum_audio_tap.sv
// Paces the column simulation at the audio rate, taps one row's amplitude per step and
// pushes it as a 32-bit audio word. DRUM_AUDIO_DC_BLOCK_EN inserts a first-order DC blocker.
module drum_audio_tap #(
  parameter int unsigned CYCLES_PER_SAMPLE = 1042,
  parameter int unsigned TAP_ROW           = 16,
  parameter int unsigned NUM_ROW           = 33,
  parameter int unsigned GAIN_SHIFT        = 0
) (
  input  logic              clk,
  input  logic              rst,
  drum_audio_tap_if.master  bus,
  output logic [15:0]       overrun_cnt
);

  localparam int unsigned CntW   = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CYCLES_PER_SAMPLE - 1);
  localparam int unsigned TapSel = (TAP_ROW < NUM_ROW) ? TAP_ROW : NUM_ROW - 1;
  localparam logic [5:0]  TapRow = 6'(TapSel);
  localparam int unsigned GainSh = (GAIN_SHIFT > 3) ? 3 : GAIN_SHIFT;

  localparam logic signed [20:0] SatHi = 21'sd131071;
  localparam logic signed [20:0] SatLo = -21'sd131072;

  typedef enum logic [1:0] {StWaitTick, StRun, StPush, StFilt} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               tick;
  logic               pending_q;
  logic [15:0]        overrun_q;
  logic               step_en_q;
  logic               valid_q;
  logic [31:0]        data_q;
  logic signed [17:0] cap_q;
  logic signed [17:0] cap_d;
  logic               tap_hit;

  // Gain, saturate to 1.17, then left-justify into the 32-bit audio word.
  function automatic logic [31:0] pack(input logic signed [17:0] x);
    logic signed [20:0] s;
    logic signed [17:0] sat;
    s = {{3{x[17]}}, x};
    s = s <<< GainSh;
    if (s > SatHi) begin
      sat = 18'sh1FFFF;
    end else if (s < SatLo) begin
      sat = 18'sh20000;
    end else begin
      sat = s[17:0];
    end
    return {sat, 14'b0};
  endfunction

  // Free-running sample-rate counter, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = (cnt_q == CntMax);

  // Same-cycle match is folded in so a tap arriving with step_done reaches the push.
  assign tap_hit = (state_q == StRun) && bus.sample_valid && (bus.row_idx == TapRow);
  assign cap_d   = tap_hit ? bus.u_sample : cap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

`ifdef DRUM_AUDIO_DC_BLOCK_EN
  logic signed [19:0] x_prev_q;
  logic signed [19:0] y_q;
  logic signed [21:0] dc_sum;
  logic signed [19:0] y_next;
  logic signed [17:0] y_sat;

  always_comb begin
    dc_sum = {{4{cap_d[17]}}, cap_d} - {{2{x_prev_q[19]}}, x_prev_q}
           + {{2{y_q[19]}}, y_q} - {{2{y_q[19]}}, (y_q >>> 8)};
    if (dc_sum > 22'sd524287) begin
      y_next = 20'sh7FFFF;
    end else if (dc_sum < -22'sd524288) begin
      y_next = 20'sh80000;
    end else begin
      y_next = dc_sum[19:0];
    end
    if (y_q > 20'sd131071) begin
      y_sat = 18'sh1FFFF;
    end else if (y_q < -20'sd131072) begin
      y_sat = 18'sh20000;
    end else begin
      y_sat = y_q[17:0];
    end
  end

  // Filter advances exactly once per step, on step_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_prev_q <= '0;
      y_q      <= '0;
    end else if ((state_q == StRun) && bus.step_done) begin
      x_prev_q <= {{2{cap_d[17]}}, cap_d};
      y_q      <= y_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StWaitTick;
      pending_q <= 1'b0;
      overrun_q <= '0;
      step_en_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      // Only one tick is remembered; every busy tick is counted.
      if (tick && (state_q != StWaitTick)) begin
        pending_q <= 1'b1;
        if (overrun_q != 16'hFFFF) begin
          overrun_q <= overrun_q + 16'd1;
        end
      end
      case (state_q)
        StWaitTick: begin
          if (tick || pending_q) begin
            state_q   <= StRun;
            step_en_q <= 1'b1;
            pending_q <= 1'b0;
          end
        end
        StRun: begin
          if (bus.step_done) begin
            step_en_q <= 1'b0;
`ifdef DRUM_AUDIO_DC_BLOCK_EN
            state_q   <= StFilt;
`else
            state_q   <= StPush;
            valid_q   <= 1'b1;
            data_q    <= pack(cap_d);
`endif
          end
        end
`ifdef DRUM_AUDIO_DC_BLOCK_EN
        StFilt: begin
          state_q <= StPush;
          valid_q <= 1'b1;
          data_q  <= pack(y_sat);
        end
`endif
        StPush: begin
          if (bus.audio_ready) begin
            state_q <= StWaitTick;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StWaitTick;
          step_en_q <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.step_en     = step_en_q;
  assign bus.audio_valid = valid_q;
  assign bus.audio_data  = data_q;
  assign overrun_cnt     = overrun_q;

endmodule

// File: tb/tb_drum_audio_tap.sv
// Directed bench for drum_audio_tap: two instances (gain 0 and gain 3) driven in lockstep.
module tb_drum_audio_tap;
  localparam int unsigned Cps = 20;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [17:0] u   = '0;
  logic        [5:0]  row = '0;
  logic               sv  = 1'b0;
  logic               sd  = 1'b0;
  logic               rdy = 1'b1;
  logic        [15:0] ovr0;
  logic        [15:0] ovr1;
  int                 n_checks = 0;
  int                 n_err    = 0;
  int                 n;

  drum_audio_tap_if if0 ();
  drum_audio_tap_if if1 ();

  assign if0.u_sample     = u;
  assign if0.row_idx      = row;
  assign if0.sample_valid = sv;
  assign if0.step_done    = sd;
  assign if0.audio_ready  = rdy;
  assign if1.u_sample     = u;
  assign if1.row_idx      = row;
  assign if1.sample_valid = sv;
  assign if1.step_done    = sd;
  assign if1.audio_ready  = rdy;

  drum_audio_tap #(
    .CYCLES_PER_SAMPLE(Cps), .TAP_ROW(16), .NUM_ROW(33), .GAIN_SHIFT(0)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(if0.master), .overrun_cnt(ovr0)
  );

  drum_audio_tap #(
    .CYCLES_PER_SAMPLE(Cps), .TAP_ROW(16), .NUM_ROW(33), .GAIN_SHIFT(3)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(if1.master), .overrun_cnt(ovr1)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // Asserts reset asynchronously and checks outputs clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    sv  = 1'b0;
    sd  = 1'b0;
    u   = '0;
    row = '0;
    rdy = 1'b1;
    #1;
    chk("rst_step_en", 32'(if0.step_en), 32'd0);
    chk("rst_valid", 32'(if0.audio_valid), 32'd0);
    chk("rst_data", if0.audio_data, 32'd0);
    chk("rst_overrun", 32'(ovr0), 32'd0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_en(input int bound, output int cnt);
    cnt = 0;
    while (!if0.step_en && cnt < bound) begin
      cycle();
      cnt++;
    end
    chk("step_en_wait", 32'(if0.step_en), 32'd1);
  endtask

  initial begin
    #2;
`ifndef DRUM_AUDIO_DC_BLOCK_EN
    do_reset();
    wait_en(40, n);
    chk("first_tick", 32'(n), 32'd20);

    // Full column traversal, row r carries r*256, done with the last row.
    for (int r = 0; r < 33; r++) begin
      row = 6'(r);
      u   = 18'(r * 256);
      sv  = 1'b1;
      sd  = (r == 32);
      if (r == 32) chk("step_en_hold", 32'(if0.step_en), 32'd1);
      cycle();
    end
    sv = 1'b0;
    sd = 1'b0;
    chk("step_en_fall", 32'(if0.step_en), 32'd0);
    chk("push_valid", 32'(if0.audio_valid), 32'd1);
    chk("basic_data", if0.audio_data, 32'h0400_0000);
    chk("basic_gain3", if1.audio_data, 32'h2000_0000);
    chk("overrun_long_step", 32'(ovr0), 32'd1);
    cycle();
    chk("valid_fall", 32'(if0.audio_valid), 32'd0);
    chk("wait_step_en", 32'(if0.step_en), 32'd0);
    cycle();
    chk("pending_run", 32'(if0.step_en), 32'd1);

    // Step with no tap: previous word repeats.
    sd = 1'b1;
    cycle();
    sd = 1'b0;
    chk("held_valid", 32'(if0.audio_valid), 32'd1);
    chk("held_capture", if0.audio_data, 32'h0400_0000);
    chk("held_gain3", if1.audio_data, 32'h2000_0000);
    cycle();
    cycle();
    cycle();
    chk("no_pending_wait", 32'(if0.step_en), 32'd0);
    cycle();
    chk("tick_aligned", 32'(if0.step_en), 32'd1);

    // Positive saturation, tap arriving with step_done.
    row = 6'd16;
    u   = 18'sh10000;
    sv  = 1'b1;
    sd  = 1'b1;
    cycle();
    sv = 1'b0;
    sd = 1'b0;
    chk("sat_pos_gain3", if1.audio_data, 32'h7FFF_C000);
    chk("pos_gain0", if0.audio_data, 32'h4000_0000);
    cycle();
    wait_en(40, n);
    chk("tick_period", 32'(n), 32'd18);

    // Two taps in one step (last wins), a non-tap row in between, negative full scale.
    row = 6'd16; u = 18'sh00400; sv = 1'b1;
    cycle();
    row = 6'd5;  u = 18'sh00123;
    cycle();
    row = 6'd16; u = 18'sh20000;
    cycle();
    sv = 1'b0;
    sd = 1'b1;
    cycle();
    sd = 1'b0;
    chk("overwrite_neg", if0.audio_data, 32'h8000_0000);
    chk("sat_neg_gain3", if1.audio_data, 32'h8000_0000);
    cycle();

    // Tap and step_done outside RUN must be ignored.
    row = 6'd16; u = 18'sh00001; sv = 1'b1; sd = 1'b1;
    wait_en(40, n);
    sv = 1'b0;
    cycle();
    sd = 1'b0;
    chk("ignore_outside_run", if0.audio_data, 32'h8000_0000);
    chk("overrun_steady", 32'(ovr0), 32'd1);
    cycle();

    // Reset in the middle of a running step.
    wait_en(40, n);
    row = 6'd16; u = 18'sh01000; sv = 1'b1;
    cycle();
    sv = 1'b0;
    do_reset();
    wait_en(40, n);
    chk("tick_after_reset", 32'(n), 32'd20);
    sd = 1'b1;
    cycle();
    sd = 1'b0;
    chk("capture_reset", if0.audio_data, 32'd0);
    cycle();

    // Backpressure: FIFO stalls for 50 cycles across two ticks.
    wait_en(40, n);
    row = 6'd16; u = 18'sh01000; sv = 1'b1; sd = 1'b1; rdy = 1'b0;
    cycle();
    sv = 1'b0;
    sd = 1'b0;
    begin
      logic stable;
      stable = 1'b1;
      for (int i = 0; i < 50; i++) begin
        cycle();
        if (!(if0.audio_valid && if0.audio_data == 32'h0400_0000)) stable = 1'b0;
      end
      chk("bp_stable", 32'(stable), 32'd1);
    end
    chk("bp_no_step", 32'(if0.step_en), 32'd0);
    rdy = 1'b1;
    cycle();
    chk("bp_valid_fall", 32'(if0.audio_valid), 32'd0);
    chk("bp_overrun", 32'(ovr0), 32'd2);
    chk("bp_overrun_gain3", 32'(ovr1), 32'd2);
    cycle();
    chk("bp_run_after_ready", 32'(if0.step_en), 32'd1);
`else
    do_reset();
    begin
      logic [31:0]        last;
      logic signed [17:0] mag;
      last = '0;
      for (int k = 0; k < 2500; k++) begin
        wait_en(40, n);
        row = 6'd16; u = 18'sh08000; sv = 1'b1; sd = 1'b1;
        cycle();
        sv = 1'b0;
        sd = 1'b0;
        if (k == 0) chk("dc_latency", 32'(if0.audio_valid), 32'd0);
        cycle();
        if (k == 0) begin
          chk("dc_valid", 32'(if0.audio_valid), 32'd1);
          chk("dc_first", if0.audio_data, 32'h2000_0000);
        end
        last = if0.audio_data;
        cycle();
      end
      mag = last[31:14];
      if (mag < 0) mag = -mag;
      chk("dc_decay", 32'(mag < 18'sh00100), 32'd1);
      chk("dc_overrun", 32'(ovr0), 32'd0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
